// File: rtl/polyveck_power2round_pkg.sv
// polyveck_power2round_pkg: shared constants and FSM state type for the power2round stage.
package polyveck_power2round_pkg;
    localparam int K = 6;
    localparam int N = 256;
    localparam int Q = 8380417;
    localparam int D = 13;
    localparam int W = 32;
    localparam int KN = K * N;
    localparam int TW = KN * W;
    typedef enum logic [2:0] {IDLE, PRE_RD_INP, RD_INP, PROC, DONE} state_t;
endpackage

// File: rtl/polyveck_power2round_lane.sv
// polyveck_power2round_lane: caddq followed by power2round on one 32-bit signed coefficient.
module polyveck_power2round_lane
    import polyveck_power2round_pkg::*;
(
    input  logic [W-1:0] a,
    output logic [W-1:0] t1,
    output logic [W-1:0] t0
);
    localparam logic signed [W-1:0] QS = W'(Q);
    localparam logic signed [W-1:0] HALF = W'((1 << (D - 1)) - 1);
    logic signed [W-1:0] ap, sum, hi;
    always_comb begin
        ap = $signed(a) + ({W{a[W-1]}} & QS);
        sum = ap + HALF;
        hi = sum >>> D;
        t1 = hi;
        t0 = ap - (hi <<< D);
    end
endmodule

// File: rtl/polyveck_power2round.sv
// polyveck_power2round: splits the latched t vector into t1/t0, LANES coefficients per cycle.
module polyveck_power2round
    import polyveck_power2round_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rtr,
    input  logic [TW-1:0] linear_t,
    output logic [TW-1:0] linear_t1,
    output logic [TW-1:0] linear_t0,
    output logic          rts
);
    localparam int IDX_W = $clog2(KN + 1);
    if (KN % LANES != 0) begin : g_bad_lanes
        $error("LANES must divide K*N");
    end
    state_t state;
    logic [IDX_W-1:0] idx;
    logic [TW-1:0] latch;
    logic [W-1:0] lane_t1 [LANES];
    logic [W-1:0] lane_t0 [LANES];
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        polyveck_power2round_lane u_lane (
            .a (latch[(int'(idx) + l) * W +: W]),
            .t1(lane_t1[l]),
            .t0(lane_t0[l])
        );
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            rts <= 1'b0;
            idx <= '0;
            latch <= '0;
            linear_t1 <= '0;
            linear_t0 <= '0;
        end else begin
            case (state)
                IDLE: state <= PRE_RD_INP;
                PRE_RD_INP: if (rtr) state <= RD_INP;
                RD_INP: begin
                    latch <= linear_t;
                    idx <= '0;
                    state <= PROC;
                end
                PROC: begin
                    for (int l = 0; l < LANES; l++) begin
                        linear_t1[(int'(idx) + l) * W +: W] <= lane_t1[l];
                        linear_t0[(int'(idx) + l) * W +: W] <= lane_t0[l];
                    end
                    idx <= idx + IDX_W'(LANES);
                    if (idx + IDX_W'(LANES) == IDX_W'(KN)) begin
                        state <= DONE;
                        rts <= 1'b1;
                    end
                end
                DONE: if (!rtr) begin
                    state <= IDLE;
                    rts <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_polyveck_power2round.sv
// tb_polyveck_power2round: directed corner/boundary vectors, handshake sequences and random jobs.
module tb_polyveck_power2round;
    import polyveck_power2round_pkg::*;
    localparam int LAT = 195;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rtr = 1'b0;
    logic [TW-1:0] linear_t = '0;
    logic [TW-1:0] linear_t1, linear_t0;
    logic rts;
    int checks = 0;
    int errors = 0;
    typedef struct {
        int c;
        int a;
        int t1;
        int t0;
    } vec_t;
    vec_t tbl[10];

    polyveck_power2round dut (
        .clock(clock),
        .reset(reset),
        .rtr(rtr),
        .linear_t(linear_t),
        .linear_t1(linear_t1),
        .linear_t0(linear_t0),
        .rts(rts)
    );

    always #5 clock = ~clock;

    function automatic void p2r(input int a, output int t1, output int t0);
        int ap;
        ap = (a < 0) ? a + Q : a;
        t1 = (ap + 4095) / 8192;
        t0 = ap - t1 * 8192;
    endfunction

    function automatic void model(input logic [TW-1:0] d, output logic [TW-1:0] e1, output logic [TW-1:0] e0);
        int a, t1, t0;
        for (int c = 0; c < KN; c++) begin
            a = d[c*W +: W];
            p2r(a, t1, t0);
            e1[c*W +: W] = t1;
            e0[c*W +: W] = t0;
        end
    endfunction

    function automatic logic [TW-1:0] rand_vec();
        logic [TW-1:0] v;
        for (int c = 0; c < KN; c++) v[c*W +: W] = int'($urandom_range(2 * Q - 2)) - (Q - 1);
        return v;
    endfunction

    task automatic check_int(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        int first;
        checks++;
        if (got !== exp) begin
            errors++;
            first = -1;
            for (int c = KN - 1; c >= 0; c--) if (got[c*W +: W] !== exp[c*W +: W]) first = c;
            $display("FAIL %s coeff %0d got %h expected %h", name, first, got[first*W +: W], exp[first*W +: W]);
        end
    endtask

    // Starts from IDLE: raises rtr and counts posedges until rts is seen high.
    task automatic run_job(input logic [TW-1:0] d, input bit scramble);
        int n;
        linear_t = d;
        rtr = 1'b1;
        n = 0;
        while (n < 400) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (scramble && n == 3) linear_t = rand_vec();
            if (rts) break;
        end
        check_int("latency", n, LAT);
    endtask

    task automatic end_job();
        rtr = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_int("rts_after_drop", rts, 0);
    endtask

    task automatic check_outputs(input string name, input logic [TW-1:0] d);
        logic [TW-1:0] e1, e0;
        model(d, e1, e0);
        check_vec({name, "_t1"}, linear_t1, e1);
        check_vec({name, "_t0"}, linear_t0, e0);
    endtask

    initial begin
        logic [TW-1:0] d, d2;
        int a, bad;
        longint r;
        tbl[0] = '{0, 4096, 0, 4096};
        tbl[1] = '{1, 4097, 1, -4095};
        tbl[2] = '{2, 8380416, 1023, 0};
        tbl[3] = '{3, -1, 1023, 0};
        tbl[4] = '{4, -8380416, 0, 1};
        tbl[5] = '{7, 8191, 1, -1};
        tbl[6] = '{8, 12288, 1, 4096};
        tbl[7] = '{255, -4096, 1023, -4095};
        tbl[8] = '{256, 1000000, 122, 576};
        tbl[9] = '{1535, -1000000, 901, -575};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_int("reset_rts", rts, 0);
        check_vec("reset_t1", linear_t1, '0);
        check_vec("reset_t0", linear_t0, '0);
        reset = 1'b0;

        // Abandon a job partway through PROC.
        linear_t = rand_vec();
        rtr = 1'b1;
        repeat (53) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        rtr = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_int("midproc_rts", rts, 0);
        check_vec("midproc_t1", linear_t1, '0);
        check_vec("midproc_t0", linear_t0, '0);
        reset = 1'b0;
        run_job('0, 1'b0);
        check_vec("zero_t1", linear_t1, '0);
        check_vec("zero_t0", linear_t0, '0);
        end_job();

        // Corners and lane/poly boundaries, with linear_t scrambled after the latch.
        d = '0;
        foreach (tbl[i]) d[tbl[i].c*W +: W] = tbl[i].a;
        run_job(d, 1'b1);
        foreach (tbl[i]) begin
            check_int($sformatf("t1_c%0d", tbl[i].c), int'(linear_t1[tbl[i].c*W +: W]), tbl[i].t1);
            check_int($sformatf("t0_c%0d", tbl[i].c), int'(linear_t0[tbl[i].c*W +: W]), tbl[i].t0);
        end
        check_outputs("table", d);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_int("rts_hold", rts, 1);
        end
        check_outputs("hold", d);
        end_job();

        d2 = rand_vec();
        run_job(d2, 1'b0);
        check_outputs("second", d2);
        end_job();

        for (int j = 0; j < 50; j++) begin
            d = rand_vec();
            run_job(d, 1'b0);
            check_outputs($sformatf("rand%0d", j), d);
            bad = 0;
            for (int c = 0; c < KN; c++) begin
                a = d[c*W +: W];
                r = (longint'(int'(linear_t1[c*W +: W])) * 8192 + longint'(int'(linear_t0[c*W +: W])) - a) % Q;
                if (r != 0) bad++;
            end
            check_int($sformatf("recon%0d", j), bad, 0);
            end_job();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/polyveck_power2round.md
Name: polyveck_power2round

Overview:
- Downstream stage of the matrix-vector pointwise product in the key-generation datapath.
- Consumes the K-poly vector t after invNTT and the s2 addition (coefficients in (-Q, Q)).
- Applies caddq, then power2round to every coefficient, producing the packed vectors t1 (high bits) and t0 (low bits) for the packing stages.
- Processes LANES coefficients per cycle with the same rtr/rts handshake as the neighbouring stages.

Parameters:
- K, 6, polynomials per vector.
- N, 256, coefficients per polynomial.
- LANES, 8, coefficients processed per cycle. Must divide K*N; elaboration error otherwise.
- Q, 8380417, modulus.
- D, 13, dropped bits.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rtr  input  1  ready-to-receive from upstream: input valid, job requested.
- linear_t  input  49152  signed packed t. Coefficient c = 256k+j is at bits [32c+31:32c], two's complement.
- linear_t1  output  49152  packed t1, same layout, registered.
- linear_t0  output  49152  packed t0, same layout, signed, registered.
- rts  output  1  ready-to-send: results valid.

Behaviour:
- Reset (synchronous, active-high) puts the FSM in IDLE and clears rts, linear_t1, linear_t0, the index counter and the input latch to 0. This applies from any state; an in-flight job is abandoned.
- FSM states and transitions:
  - IDLE: 1 cycle -> PRE_RD_INP.
  - PRE_RD_INP: wait for rtr=1 -> RD_INP.
  - RD_INP: latch linear_t into internal register; clear index idx=0 -> PROC.
  - PROC: each cycle process coefficients idx..idx+LANES-1 from the latch, write them into the t1/t0 output registers, idx += LANES. When idx+LANES == K*N, that cycle writes the last group -> DONE.
  - DONE: rts=1. rtr=0 -> IDLE; rtr=1 -> stay in DONE.
- rts is a Moore output: 1 only in DONE.
- Latency:
  - rtr sampled high in PRE_RD_INP at edge E.
  - RD_INP during E..E+1.
  - PROC for K*N/LANES cycles (192 with defaults).
  - rts rises K*N/LANES+1 cycles after E (193 with defaults).
- linear_t may change after the RD_INP edge without affecting the job. rtr changes during RD_INP/PROC are ignored; the job always completes.
- Outputs hold their values from DONE until the next job overwrites them group by group, or reset. They are not valid while rts=0.
- A new job needs the full cycle DONE -> IDLE -> PRE_RD_INP -> rtr=1. Holding rtr high continuously does not retrigger a job.
- Per-coefficient arithmetic (32-bit signed a):
  - a' = a + ((a >>> 31) & Q)
  - t1 = (a' + (1<<(D-1)) - 1) >>> D
  - t0 = a' - (t1 << D)
- Guaranteed ranges for inputs in (-Q, Q):
  - t1 in [0, 1023], zero-extended to 32 bits.
  - t0 in (-4096, 4096], sign-extended to 32 bits.
- No saturation; out-of-range inputs give arithmetically defined but unspecified results.

Decomposition:
- Shared package / include: Q, D, N, K, coefficient width 32.
- Sub-module power2round_lane: purely combinational, 32-bit a -> 32-bit t1, 32-bit t0. Instantiated LANES times in a generate loop.
- Top level holds the FSM, counter, input latch and output registers.

Test Plan:
- Reset mid-PROC (assert reset at cycle 50 of PROC): next cycle rts=0 and outputs all 0. Then run a job with every coefficient = 0: t1=0, t0=0, rts rises exactly 193 cycles after the rtr-sampling edge.
- Corner values (a=4096, 4097, 8380416, -1, -8380416 in coeffs 0..4 of poly 0):
  - a=4096 -> t1=0, t0=4096.
  - a=4097 -> t1=1, t0=-4095 (0xFFFFF001).
  - a=8380416 -> t1=1023, t0=0.
  - a=-1 -> t1=1023, t0=0.
  - a=-8380416 -> t1=0, t0=1.
- Lane/poly boundaries: distinct values at coeffs 7, 8, 255, 256, 1535; each lands at the matching output offset (e.g. coeff 1535 at bits [49151:49120]).
- Input latch: change linear_t to random data the cycle after RD_INP; outputs match the originally latched data.
- Handshake: hold rtr=1 in DONE for 10 cycles -> rts stays 1, no new job. Drop rtr -> IDLE next cycle. Re-raise rtr -> second job with new data completes with correct results.
- Random regression: 50 jobs with uniform coefficients in (-Q, Q), compared against a software power2round/caddq model. Check t1 + t0*1 reconstruction: (t1<<13)+t0 == a mod Q for all coefficients.
